// File: rtl/output_port_scheduler.sv
// rtl/output_port_scheduler.sv - credit-gated round-robin output port arbiter with packet locking.
// Optional stall watchdog: define OUTPUT_PORT_SCHEDULER_WDOG_EN.
module output_port_scheduler #(
  parameter int NUM_REQUESTERS = 4,
  parameter int CREDIT_DEPTH   = 4,
  parameter int WDOG_LIMIT     = 64
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQUESTERS-1:0]           request,
  input  logic [NUM_REQUESTERS-1:0]           is_tail,
  input  logic                                credit_return,
  output logic [NUM_REQUESTERS-1:0]           grant_oh,
  output logic                                flit_sent,
  output logic                                locked,
  output logic [$clog2(CREDIT_DEPTH+1)-1:0]   credits,
  output logic                                credit_overflow,
  output logic                                wdog_error
);

  localparam int IW = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
  localparam int CW = $clog2(CREDIT_DEPTH + 1);

  if (NUM_REQUESTERS < 1 || CREDIT_DEPTH < 1 || WDOG_LIMIT < 1) begin : g_param_check
    $error("output_port_scheduler: parameters must all be >= 1");
  end

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [IW-1:0]       r_owner;
  logic [IW-1:0]       r_last_winner;
  logic [CW-1:0]       r_credits;
  logic                r_credit_overflow;

  logic                w_rr_valid;
  logic [IW-1:0]       w_rr_winner;
  logic [IW-1:0]       w_cand;
  logic                w_credit_ok;
  logic                w_grant_valid;
  logic [IW-1:0]       w_grant_idx;
  logic                w_tail;
  logic                w_idle_grant;
  logic                w_wdog_fire;

  // Search starts one past the last head-flit winner, wrapping around.
  always_comb begin
    w_rr_valid  = 1'b0;
    w_rr_winner = '0;
    w_cand      = '0;
    for (int i = 1; i <= NUM_REQUESTERS; i++) begin
      w_cand = IW'((32'(r_last_winner) + i) % NUM_REQUESTERS);
      if (!w_rr_valid && request[w_cand]) begin
        w_rr_valid  = 1'b1;
        w_rr_winner = w_cand;
      end
    end
  end

  assign w_credit_ok = (r_credits != '0);

  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_idx   = '0;
    if (!reset && w_credit_ok) begin
      if (r_state == IDLE) begin
        w_grant_valid = w_rr_valid;
        w_grant_idx   = w_rr_winner;
      end else begin
        w_grant_valid = request[r_owner];
        w_grant_idx   = r_owner;
      end
    end
  end

  assign w_tail       = is_tail[w_grant_idx];
  assign w_idle_grant = w_grant_valid && (r_state == IDLE);
  assign grant_oh     = w_grant_valid ? (NUM_REQUESTERS'(1) << w_grant_idx) : '0;
  assign flit_sent    = w_grant_valid;

`ifdef OUTPUT_PORT_SCHEDULER_WDOG_EN
  localparam int WW = $clog2(WDOG_LIMIT + 1);
  logic [WW-1:0] r_wdog_cnt;
  logic          r_wdog_error;

  assign w_wdog_fire = (r_state == LOCKED) && !w_grant_valid
                       && (r_wdog_cnt == WW'(WDOG_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wdog_cnt   <= '0;
      r_wdog_error <= 1'b0;
    end else begin
      r_wdog_error <= w_wdog_fire;
      if (r_state != LOCKED || w_grant_valid || w_wdog_fire)
        r_wdog_cnt <= '0;
      else
        r_wdog_cnt <= r_wdog_cnt + WW'(1);
    end
  end

  assign wdog_error = r_wdog_error;
`else
  assign w_wdog_fire = 1'b0;
  assign wdog_error  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= IDLE;
    else
      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_valid && !w_tail)
          w_next_state = LOCKED;
      end
      LOCKED: begin
        if (w_grant_valid && w_tail)
          w_next_state = IDLE;
        else if (w_wdog_fire)
          w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner           <= '0;
      r_last_winner     <= IW'(NUM_REQUESTERS - 1);
      r_credits         <= CW'(CREDIT_DEPTH);
      r_credit_overflow <= 1'b0;
    end else begin
      // Only head flits advance the round-robin pointer.
      if (w_idle_grant) begin
        r_last_winner <= w_grant_idx;
        if (!w_tail)
          r_owner <= w_grant_idx;
      end
      r_credit_overflow <= 1'b0;
      if (w_grant_valid && !credit_return) begin
        r_credits <= r_credits - CW'(1);
      end else if (credit_return && !w_grant_valid) begin
        if (r_credits == CW'(CREDIT_DEPTH))
          r_credit_overflow <= 1'b1;
        else
          r_credits <= r_credits + CW'(1);
      end
    end
  end

  assign locked          = (r_state == LOCKED);
  assign credits         = r_credits;
  assign credit_overflow = r_credit_overflow;

endmodule

// File: tb/tb_output_port_scheduler.sv
// tb/tb_output_port_scheduler.sv - directed table-driven bench for output_port_scheduler.
module tb_output_port_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] request = '0;
  logic [3:0] is_tail = '0;
  logic       credit_return = 1'b0;
  logic [3:0] grant_oh;
  logic       flit_sent;
  logic       locked;
  logic [2:0] credits;
  logic       credit_overflow;
  logic       wdog_error;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  output_port_scheduler #(
    .NUM_REQUESTERS(4),
    .CREDIT_DEPTH(4),
    .WDOG_LIMIT(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .request(request),
    .is_tail(is_tail),
    .credit_return(credit_return),
    .grant_oh(grant_oh),
    .flit_sent(flit_sent),
    .locked(locked),
    .credits(credits),
    .credit_overflow(credit_overflow),
    .wdog_error(wdog_error)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] tail;
    logic       cret;
    logic [3:0] e_grant;
    logic       e_locked;
    logic [2:0] e_credits;
    logic       e_ovf;
    logic       e_wdog;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [3:0] req, input logic [3:0] tail,
                     input logic cret, input logic [3:0] eg, input logic el,
                     input logic [2:0] ec, input logic eo, input logic ew);
    vec_t v;
    v.rst = rst; v.req = req; v.tail = tail; v.cret = cret;
    v.e_grant = eg; v.e_locked = el; v.e_credits = ec; v.e_ovf = eo; v.e_wdog = ew;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int step, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s step=%0d actual=%0h required=%0h", name, step, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic apply(input int step, input logic rst, input logic [3:0] req,
                       input logic [3:0] tail, input logic cret, input logic [3:0] eg,
                       input logic el, input logic [2:0] ec, input logic eo, input logic ew);
    @(negedge clk);
    reset = rst; request = req; is_tail = tail; credit_return = cret;
    #1;
    chk("grant_oh", step, int'(grant_oh), int'(eg));
    chk("flit_sent", step, int'(flit_sent), int'(|eg));
    chk("locked", step, int'(locked), int'(el));
    chk("credits", step, int'(credits), int'(ec));
    chk("credit_overflow", step, int'(credit_overflow), int'(eo));
    chk("wdog_error", step, int'(wdog_error), int'(ew));
  endtask

  initial begin
    //   rst req      tail     cret grant    lk cr   ovf wd
    add(1, 4'b1111, 4'b1111, 0, 4'b0000, 0, 3'd4, 0, 0);
    // single-flit round robin drains credits
    add(0, 4'b1111, 4'b1111, 0, 4'b0001, 0, 3'd4, 0, 0);
    add(0, 4'b1111, 4'b1111, 0, 4'b0010, 0, 3'd3, 0, 0);
    add(0, 4'b1111, 4'b1111, 0, 4'b0100, 0, 3'd2, 0, 0);
    add(0, 4'b1111, 4'b1111, 0, 4'b1000, 0, 3'd1, 0, 0);
    add(0, 4'b1111, 4'b1111, 0, 4'b0000, 0, 3'd0, 0, 0);
    // refill, then overflow at full
    add(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 3'd0, 0, 0);
    add(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 3'd1, 0, 0);
    add(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 3'd2, 0, 0);
    add(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 3'd3, 0, 0);
    add(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 3'd4, 0, 0);
    add(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 3'd4, 0, 0);
    add(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 3'd4, 1, 0);
    add(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 3'd4, 0, 0);
    // send and return in the same cycle at credits=2
    add(0, 4'b0001, 4'b0001, 0, 4'b0001, 0, 3'd4, 0, 0);
    add(0, 4'b0010, 4'b0010, 0, 4'b0010, 0, 3'd3, 0, 0);
    add(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 3'd2, 0, 0);
    add(0, 4'b0100, 4'b0100, 1, 4'b0100, 0, 3'd2, 0, 0);
    add(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 3'd2, 0, 0);
    add(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 3'd2, 0, 0);
    add(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 3'd3, 0, 0);
    // 3-flit packet on input 1 while input 2 keeps requesting
    add(0, 4'b0110, 4'b0100, 0, 4'b0010, 0, 3'd4, 0, 0);
    add(0, 4'b0110, 4'b0100, 0, 4'b0010, 1, 3'd3, 0, 0);
    add(0, 4'b0110, 4'b0110, 0, 4'b0010, 1, 3'd2, 0, 0);
    add(0, 4'b0100, 4'b0100, 0, 4'b0100, 0, 3'd1, 0, 0);
    // locked with zero credits, one credit returned
    add(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 3'd0, 0, 0);
    add(0, 4'b1000, 4'b0000, 0, 4'b1000, 0, 3'd1, 0, 0);
    add(0, 4'b1000, 4'b0000, 0, 4'b0000, 1, 3'd0, 0, 0);
    add(0, 4'b1000, 4'b0000, 1, 4'b0000, 1, 3'd0, 0, 0);
    add(0, 4'b1000, 4'b0000, 0, 4'b1000, 1, 3'd1, 0, 0);
    add(0, 4'b1000, 4'b0000, 0, 4'b0000, 1, 3'd0, 0, 0);
    // reset mid-packet, then requester 0 wins
    add(1, 4'b1000, 4'b0000, 0, 4'b0000, 1, 3'd0, 0, 0);
    add(0, 4'b1001, 4'b1001, 0, 4'b0001, 0, 3'd4, 0, 0);
    add(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 3'd3, 0, 0);

    reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < vecs.size(); i++)
      apply(i, vecs[i].rst, vecs[i].req, vecs[i].tail, vecs[i].cret, vecs[i].e_grant,
            vecs[i].e_locked, vecs[i].e_credits, vecs[i].e_ovf, vecs[i].e_wdog);

    // Owner 1 stalls mid-packet; requesters 0 and 2 must be ignored while locked.
    apply(100, 0, 4'b0010, 4'b0000, 0, 4'b0010, 0, 3'd3, 0, 0);
    for (int s = 0; s < 8; s++)
      apply(101 + s, 0, 4'b0101, 4'b0100, 0, 4'b0000, 1, 3'd2, 0, 0);
`ifdef OUTPUT_PORT_SCHEDULER_WDOG_EN
    apply(110, 0, 4'b0101, 4'b0100, 0, 4'b0100, 0, 3'd2, 0, 1);
    apply(111, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 3'd1, 0, 0);
`else
    for (int s = 0; s < 20; s++)
      apply(110 + s, 0, 4'b0101, 4'b0100, 0, 4'b0000, 1, 3'd2, 0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
